// File: rtl/prog_loader_if.sv
// Valid/ready word stream that carries a framed program into the loader.
interface prog_loader_if #(
    parameter int W = 9
);
    logic [W-1:0] InData;
    logic         InValid;
    logic         InReady;

    modport master (output InData, output InValid, input InReady);
    modport slave  (input InData, input InValid, output InReady);
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory writer: clears the RAM, takes a length-framed program with a
// checksum trailer, then releases the processor, which fetches via a registered read port.
module prog_loader #(
    parameter int W     = 9,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    prog_loader_if.slave  s_if,
    input  logic [AW-1:0] RdAddr,
    output logic [W-1:0]  RdData,
    output logic          CpuResetn,
    output logic          Busy,
    output logic          LoadDone,
    output logic          LoadErr,
    output logic [AW:0]   WordCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    localparam logic [AW:0]  LAST_PTR = (AW+1)'(DEPTH - 1);
    localparam logic [W-1:0] DEPTH_W  = W'(DEPTH);

    state_e         state_q, state_d;
    logic [AW:0]    ptr_q, ptr_d;
    logic [AW:0]    len_q, len_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           in_ready_q;
    logic           cpu_rstn_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic [W-1:0]   rd_data_q;
    logic [W-1:0]   mem [DEPTH];

    logic           acc_s;
    logic           we_s;
    logic [AW-1:0]  waddr_s;
    logic [W-1:0]   wdata_s;

    assign acc_s       = s_if.InValid & in_ready_q;
    assign s_if.InReady = in_ready_q;
    assign RdData      = rd_data_q;
    assign CpuResetn   = cpu_rstn_q;
    assign Busy        = busy_q;
    assign LoadDone    = done_q;
    assign LoadErr     = err_q;
    assign WordCount   = cnt_q;

    // Next-state, datapath updates and the single RAM write port.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_s    = 1'b0;
        waddr_s = ptr_q[AW-1:0];
        wdata_s = {W{1'b0}};
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (Start) begin
                    state_d = S_CLEAR;
                    ptr_d   = {(AW+1){1'b0}};
                    cnt_d   = {(AW+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_CLEAR: begin
                we_s = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = S_LEN;
                    ptr_d   = {(AW+1){1'b0}};
                end else begin
                    ptr_d = ptr_q + (AW+1)'(1);
                end
            end
            S_LEN: begin
                if (acc_s) begin
                    if ((s_if.InData == {W{1'b0}}) || (s_if.InData > DEPTH_W)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        len_d   = s_if.InData[AW:0];
                        ptr_d   = {(AW+1){1'b0}};
                        cnt_d   = {(AW+1){1'b0}};
                        sum_d   = {W{1'b0}};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (acc_s) begin
                    we_s    = 1'b1;
                    wdata_s = s_if.InData;
                    ptr_d   = ptr_q + (AW+1)'(1);
                    cnt_d   = cnt_q + (AW+1)'(1);
                    sum_d   = sum_q + s_if.InData;
                    if ((cnt_q + (AW+1)'(1)) == len_q) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_CSUM: begin
                if (acc_s) begin
                    if (s_if.InData == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath registers and outputs decoded from the next state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            ptr_q      <= {(AW+1){1'b0}};
            len_q      <= {(AW+1){1'b0}};
            cnt_q      <= {(AW+1){1'b0}};
            sum_q      <= {W{1'b0}};
            in_ready_q <= 1'b0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            in_ready_q <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
            busy_q     <= (state_d == S_CLEAR) || (state_d == S_LEN) ||
                          (state_d == S_DATA) || (state_d == S_CSUM);
            cpu_rstn_q <= (state_d == S_RUN);
            done_q     <= (state_d == S_RUN) && (state_q != S_RUN);
            err_q      <= (state_d == S_ERR);
        end
    end

    // Instruction RAM write port; contents survive reset.
    always_ff @(posedge Clock) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    // Registered fetch port; sees pre-write data on a same-address collision.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_data_q <= {W{1'b0}};
        end else begin
            rd_data_q <= mem[RdAddr];
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized program loads checked against a RAM/checksum model.
module tb_prog_loader;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic [4:0] RdAddr;
    logic [8:0] RdData;
    logic       CpuResetn;
    logic       Busy;
    logic       LoadDone;
    logic       LoadErr;
    logic [5:0] WordCount;

    prog_loader_if #(.W(9)) bus ();

    prog_loader #(.W(9), .DEPTH(32), .AW(5)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .s_if      (bus),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .CpuResetn (CpuResetn),
        .Busy      (Busy),
        .LoadDone  (LoadDone),
        .LoadErr   (LoadErr),
        .WordCount (WordCount)
    );

    int         vectors;
    int         miscompares;
    logic [8:0] ref_mem [32];
    logic [8:0] w [32];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(w[i]);
        return 9'(s % 512);
    endfunction

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            RdAddr = 5'(a);
            tick();
            chk($sformatf("rd%0d", a), 32'(RdData), 32'(ref_mem[a]));
        end
    endtask

    task automatic start_load();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("busy_clear", 32'(Busy), 32'd1);
        chk("cpurst_clear", 32'(CpuResetn), 32'd0);
        chk("err_cleared", 32'(LoadErr), 32'd0);
        chk("wc_clear", 32'(WordCount), 32'd0);
        repeat (31) tick();
        chk("rdy_in_clear", 32'(bus.InReady), 32'd0);
        tick();
        chk("rdy_after_clear", 32'(bus.InReady), 32'd1);
        for (int a = 0; a < 32; a++) ref_mem[a] = 9'h000;
    endtask

    task automatic send(input logic [8:0] word, input bit stall, input bit poke);
        bit rdy;
        int guard;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                bus.InValid = 1'b0;
                bus.InData  = 9'($urandom);
                Start       = poke;
                tick();
                Start = 1'b0;
            end
        end
        bus.InValid = 1'b1;
        bus.InData  = word;
        guard = 0;
        forever begin
            rdy = bus.InReady;
            tick();
            if (rdy) break;
            guard++;
            if (guard > 100) begin
                chk("ready_timeout", 32'(rdy), 32'd1);
                break;
            end
        end
        bus.InValid = 1'b0;
    endtask

    task automatic run_load(input int n, input logic [8:0] csum, input bit stall, input bit poke);
        bit ok;
        start_load();
        send(9'(n), stall, 1'b0);
        if (n < 1 || n > 32) begin
            chk("lenerr_err", 32'(LoadErr), 32'd1);
            chk("lenerr_cpu", 32'(CpuResetn), 32'd0);
            chk("lenerr_busy", 32'(Busy), 32'd0);
            chk("lenerr_wc", 32'(WordCount), 32'd0);
            read_all();
            return;
        end
        for (int i = 0; i < n; i++) begin
            send(w[i], stall, poke);
            ref_mem[i] = w[i];
        end
        chk("wc_pre_csum", 32'(WordCount), 32'(n));
        chk("busy_pre_csum", 32'(Busy), 32'd1);
        send(csum, stall, 1'b0);
        ok = (csum == model_sum(n));
        if (ok) begin
            chk("done_pulse", 32'(LoadDone), 32'd1);
            chk("run_cpu", 32'(CpuResetn), 32'd1);
            chk("run_err", 32'(LoadErr), 32'd0);
            tick();
            chk("done_low", 32'(LoadDone), 32'd0);
            chk("run_cpu2", 32'(CpuResetn), 32'd1);
        end else begin
            chk("csum_err", 32'(LoadErr), 32'd1);
            chk("csum_cpu", 32'(CpuResetn), 32'd0);
            chk("csum_done", 32'(LoadDone), 32'd0);
        end
        chk("wc_final", 32'(WordCount), 32'(n));
        read_all();
    endtask

    task automatic set_nominal();
        w[0] = 9'h040; w[1] = 9'h005; w[2] = 9'h008; w[3] = 9'h081; w[4] = 9'h0C0;
    endtask

    initial begin
        int n;
        logic [8:0] cs;
        vectors     = 0;
        miscompares = 0;
        Resetn      = 1'b0;
        Start       = 1'b0;
        RdAddr      = 5'd0;
        bus.InData  = 9'h000;
        bus.InValid = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.InReady), 32'd0);
        chk("rst_cpu", 32'(CpuResetn), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(LoadDone), 32'd0);
        chk("rst_err", 32'(LoadErr), 32'd0);
        chk("rst_wc", 32'(WordCount), 32'd0);
        chk("rst_rd", 32'(RdData), 32'd0);
        #1 Resetn = 1'b1;
        tick();

        // nominal load
        set_nominal();
        run_load(5, 9'h18E, 1'b0, 1'b0);
        // bad checksum, then a reload that must clear LoadErr
        run_load(5, 9'h18F, 1'b0, 1'b0);
        // bad lengths
        run_load(0, 9'h000, 1'b0, 1'b0);
        run_load(33, 9'h000, 1'b0, 1'b0);
        // stalls and Start pulses during DATA
        set_nominal();
        run_load(5, 9'h18E, 1'b1, 1'b1);
        // full-depth boundary
        for (int i = 0; i < 32; i++) w[i] = 9'h1FF;
        run_load(32, 9'h1E0, 1'b0, 1'b0);
        // random programs, alternating good and bad checksums
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 32));
            for (int i = 0; i < 32; i++) w[i] = 9'($urandom);
            cs = model_sum(n);
            if (r % 2 == 1) cs = cs + 9'(1 + $urandom_range(0, 510));
            run_load(n, cs, 1'b1, 1'b1);
        end

        // reset in the middle of DATA
        set_nominal();
        start_load();
        send(9'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(w[i], 1'b0, 1'b0);
            ref_mem[i] = w[i];
        end
        Resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.InReady), 32'd0);
        chk("mid_rst_cpu", 32'(CpuResetn), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_wc", 32'(WordCount), 32'd0);
        chk("mid_rst_err", 32'(LoadErr), 32'd0);
        chk("mid_rst_rd", 32'(RdData), 32'd0);
        #2 Resetn = 1'b1;
        tick();
        tick();
        chk("post_rst_idle_rdy", 32'(bus.InReady), 32'd0);
        chk("post_rst_idle_busy", 32'(Busy), 32'd0);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
